// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// flush-to-bubble and a saturating stall counter.
module pipe_stage_skid_reg #(
  parameter int unsigned     WIDTH      = 32,
  parameter bit              SKID_EN    = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [CNT_W-1:0] stall_q;

  logic acc;
  logic ret;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

  // Ready source: from state flops with a skid entry, otherwise combinational
  // pass-through of downstream ready.
  generate
    if (SKID_EN) begin : g_ready_reg
      assign in_ready = (state_q != ST_SKID);
    end else begin : g_ready_comb
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign acc = in_valid && in_ready;
  assign ret = out_valid && out_ready;

  // Entry FSM: main/skid storage; flush overrides any accept or return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_q <= ST_FULL;
            main_q  <= in_data;
          end
        end
        ST_FULL: begin
          if (acc && ret) begin
            main_q <= in_data;
          end else if (acc && SKID_EN) begin
            state_q <= ST_SKID;
            skid_q  <= in_data;
          end else if (ret) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (ret) begin
            state_q <= ST_FULL;
            main_q  <= skid_q;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles where output is offered but not taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: skid, no-skid and narrow-counter variants.
module tb_pipe_stage_skid_reg;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Instance A: skid enabled, 32-bit, NOP bubble
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [15:0] a_stall;

  pipe_stage_skid_reg #(
    .WIDTH(32), .SKID_EN(1'b1), .BUBBLE_VAL(32'h0000_0013), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stall_cnt(a_stall)
  );

  // Instance B: no skid, combinational ready
  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [15:0] b_stall;

  pipe_stage_skid_reg #(
    .WIDTH(8), .SKID_EN(1'b0), .BUBBLE_VAL(8'h00), .CNT_W(16)
  ) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall_cnt(b_stall)
  );

  // Instance C: 4-bit stall counter
  logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data, c_out_data;
  logic [3:0] c_stall;

  pipe_stage_skid_reg #(
    .WIDTH(8), .SKID_EN(1'b1), .BUBBLE_VAL(8'h00), .CNT_W(4)
  ) u_c (
    .clk(clk), .rst(rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .stall_cnt(c_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_flush = 0; c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
    #1;
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_out_data",  a_out_data, 32'd0);
    chk("rst_stall",     {16'b0, a_stall}, 32'd0);
    chk("rst_in_ready",  {31'b0, a_in_ready}, 32'd1);
    chk("rst_b_in_ready", {31'b0, b_in_ready}, 32'd1);
    #10 rst = 1'b0;
    step();

    // 1: streaming 1..8 with downstream always ready
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_data = 32'(i);
      #1;
      chk("stream_in_ready", {31'b0, a_in_ready}, 32'd1);
      step();
      chk("stream_data",  a_out_data, 32'(i));
      chk("stream_valid", {31'b0, a_out_valid}, 32'd1);
    end
    a_in_valid = 1'b0;
    a_in_data  = 32'hDEAD_BEEF;
    step();
    chk("drain_valid",  {31'b0, a_out_valid}, 32'd0);
    chk("drain_hold",   a_out_data, 32'd8);
    chk("stream_stall", {16'b0, a_stall}, 32'd0);

    // 2: backpressure A, B, C
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'hA;
    #1 chk("bp_rdy_A", {31'b0, a_in_ready}, 32'd1);
    step();
    a_in_data = 32'hB;
    #1 chk("bp_rdy_B", {31'b0, a_in_ready}, 32'd1);
    step();
    a_in_data = 32'hC;
    #1 chk("bp_rdy_C", {31'b0, a_in_ready}, 32'd0);
    chk("bp_hold_A", a_out_data, 32'hA);
    step();
    step();
    chk("bp_hold_A2", a_out_data, 32'hA);
    chk("bp_stall3",  {16'b0, a_stall}, 32'd3);
    a_out_ready = 1'b1;
    #1 chk("bp_rdy_skid", {31'b0, a_in_ready}, 32'd0);
    step();
    chk("bp_out_B",   a_out_data, 32'hB);
    chk("bp_rdy_full", {31'b0, a_in_ready}, 32'd1);
    step();
    chk("bp_out_C",   a_out_data, 32'hC);
    a_in_valid = 1'b0;
    step();
    chk("bp_empty",   {31'b0, a_out_valid}, 32'd0);
    chk("bp_stall_final", {16'b0, a_stall}, 32'd3);

    // 3: flush while in SKID with a payload on offer
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h21;
    step();
    a_in_data = 32'h22;
    step();
    chk("fl_pre_rdy", {31'b0, a_in_ready}, 32'd0);
    a_flush   = 1'b1;
    a_in_data = 32'h55;
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    chk("fl_valid",  {31'b0, a_out_valid}, 32'd0);
    chk("fl_bubble", a_out_data, 32'h13);
    chk("fl_ready",  {31'b0, a_in_ready}, 32'd1);
    chk("fl_stall",  {16'b0, a_stall}, 32'd5);
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_55_valid", {31'b0, a_out_valid}, 32'd0);
      chk("fl_no_55_data",  a_out_data, 32'h13);
    end

    // 4: no-skid variant, combinational ready
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h41;
    #1 chk("ns_rdy_empty", {31'b0, b_in_ready}, 32'd1);
    step();
    chk("ns_out_41", {24'b0, b_out_data}, 32'h41);
    chk("ns_rdy_stall", {31'b0, b_in_ready}, 32'd0);
    b_out_ready = 1'b1;
    #1 chk("ns_rdy_comb", {31'b0, b_in_ready}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      b_in_data = 8'(8'h40 + i);
      #1 chk("ns_rdy_tp", {31'b0, b_in_ready}, 32'd1);
      step();
      chk("ns_data_tp", {24'b0, b_out_data}, 32'(8'h40 + i));
      chk("ns_valid_tp", {31'b0, b_out_valid}, 32'd1);
    end
    b_out_ready = 1'b0;
    b_in_data   = 8'h99;
    #1 chk("ns_rdy_drop", {31'b0, b_in_ready}, 32'd0);
    step();
    chk("ns_hold_45", {24'b0, b_out_data}, 32'h45);
    b_in_valid = 1'b0;

    // 5: async reset while in SKID
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h31;
    step();
    a_in_data = 32'h32;
    step();
    a_in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'b0, a_out_valid}, 32'd0);
    chk("ar_data",  a_out_data, 32'd0);
    chk("ar_stall", {16'b0, a_stall}, 32'd0);
    chk("ar_ready", {31'b0, a_in_ready}, 32'd1);
    #2 rst = 1'b0;
    step();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h77;
    step();
    a_in_valid = 1'b0;
    chk("ar_new_data",  a_out_data, 32'h77);
    chk("ar_new_valid", {31'b0, a_out_valid}, 32'd1);

    // 6: 4-bit stall counter saturates at 15
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_in_data   = 8'h01;
    step();
    c_in_valid = 1'b0;
    chk("sat_start", {28'b0, c_stall}, 32'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("sat_14", {28'b0, c_stall}, 32'd14);
      if (i == 15) chk("sat_15", {28'b0, c_stall}, 32'd15);
    end
    chk("sat_hold", {28'b0, c_stall}, 32'd15);
    chk("sat_data", {24'b0, c_out_data}, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
